// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory port between the core (m0) and the loader (m1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 1 always wins ties.

module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              pick1;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 when port 1 was granted last; resets to 1 so the first tie goes to port 0.
  logic last_q, last_d;
  assign pick1 = m1_req & (~m0_req | ~last_q);
`else
  assign pick1 = m1_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 3'd0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          state_d = StIssue;
          grant_d = pick1 ? 2'b10 : 2'b01;
          we_d    = pick1 ? m1_we : m0_we;
          addr_d  = pick1 ? m1_addr : m0_addr;
          wdata_d = pick1 ? m1_wdata : m0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick1;
`endif
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          cnt_d   = 3'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          if (grant_q[1]) m1_rdata_d = mem_rdata;
          else            m0_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StIssue) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    m0_ack   = (state_q == StDone) & grant_q[0];
    m1_ack   = (state_q == StDone) & grant_q[1];
    busy     = (state_q != StIdle);
    grant    = grant_q;
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
  end

endmodule
